// File: rtl/set_bit_index_iterator_pkg.sv
// Shared types and helpers for the set-bit index iterator.
package set_bit_index_iterator_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } iter_state_t;

    localparam int DEFAULT_WORD_WIDTH = 8;

    // Index must hold 0..w inclusive; w itself flags an all-zero word.
    function automatic int calc_index_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int DEFAULT_INDEX_WIDTH = calc_index_width(DEFAULT_WORD_WIDTH);

endpackage

// File: rtl/set_bit_index_iterator_lsb.sv
// Combinational lowest-set-bit finder: one-hot isolate, then encode to binary.
module lowest_set_bit_index
    import set_bit_index_iterator_pkg::*;
#(
    parameter int WORD_WIDTH  = DEFAULT_WORD_WIDTH,
    parameter int INDEX_WIDTH = calc_index_width(WORD_WIDTH)
) (
    input  logic [WORD_WIDTH-1:0]  i_word,
    output logic [INDEX_WIDTH-1:0] o_index,
    output logic                   o_zero,
    output logic [WORD_WIDTH-1:0]  o_onehot
);

    logic [WORD_WIDTH-1:0] w_onehot;

    // Two's-complement trick leaves only the rightmost 1.
    assign w_onehot = i_word & (~i_word + 1'b1);
    assign o_onehot = w_onehot;
    assign o_zero   = (i_word == '0);

    // One-hot to binary; an empty word reports WORD_WIDTH.
    always_comb begin
        o_index = '0;
        for (int i = 0; i < WORD_WIDTH; i++) begin
            if (w_onehot[i]) begin
                o_index = INDEX_WIDTH'(i);
            end
        end
        if (o_zero) begin
            o_index = INDEX_WIDTH'(WORD_WIDTH);
        end
    end

endmodule

// File: rtl/set_bit_index_iterator.sv
// Accepts a bitmask and emits the index of each set bit, one per cycle.
//   state | meaning
//   IDLE  | waiting for a word, input_ready high
//   EMIT  | presenting indices from the residual word
module set_bit_index_iterator
    import set_bit_index_iterator_pkg::*;
#(
    parameter int WORD_WIDTH    = DEFAULT_WORD_WIDTH,
    parameter bit SCAN_FROM_MSB = 1'b0,
    localparam int INDEX_WIDTH  = calc_index_width(WORD_WIDTH)
) (
    input  logic                   i_clock,
    input  logic                   i_clear,
    input  logic [WORD_WIDTH-1:0]  i_input_word,
    input  logic                   i_input_valid,
    output logic                   o_input_ready,
    output logic [INDEX_WIDTH-1:0] o_output_index,
    output logic                   o_output_last,
    output logic                   o_output_empty,
    output logic                   o_output_valid,
    input  logic                   i_output_ready
);

    iter_state_t r_state;
    iter_state_t w_state_next;

    logic [WORD_WIDTH-1:0]  r_residual;
    logic [WORD_WIDTH-1:0]  w_scan_word;
    logic [WORD_WIDTH-1:0]  w_scan_mask;
    logic [WORD_WIDTH-1:0]  w_emit_mask;
    logic [WORD_WIDTH-1:0]  w_remaining;
    logic [INDEX_WIDTH-1:0] w_scan_index;
    logic [INDEX_WIDTH-1:0] w_emit_index;
    logic                   w_zero;
    logic                   w_last;
    logic                   w_in_hs;
    logic                   w_out_hs;

    // MSB-first reuses the LSB finder on a bit-reversed word.
    always_comb begin
        w_scan_word = '0;
        w_emit_mask = '0;
        for (int i = 0; i < WORD_WIDTH; i++) begin
            if (SCAN_FROM_MSB) begin
                w_scan_word[i] = r_residual[WORD_WIDTH-1-i];
                w_emit_mask[i] = w_scan_mask[WORD_WIDTH-1-i];
            end else begin
                w_scan_word[i] = r_residual[i];
                w_emit_mask[i] = w_scan_mask[i];
            end
        end
    end

    lowest_set_bit_index #(
        .WORD_WIDTH  (WORD_WIDTH),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_lsb (
        .i_word   (w_scan_word),
        .o_index  (w_scan_index),
        .o_zero   (w_zero),
        .o_onehot (w_scan_mask)
    );

    // Map the reversed-domain index back; the empty code stays WORD_WIDTH.
    always_comb begin
        if (SCAN_FROM_MSB && !w_zero) begin
            w_emit_index = INDEX_WIDTH'(WORD_WIDTH - 1) - w_scan_index;
        end else begin
            w_emit_index = w_scan_index;
        end
    end

    assign w_remaining = r_residual & ~w_emit_mask;
    assign w_last      = (w_remaining == '0);
    assign w_in_hs     = i_input_valid & o_input_ready;
    assign w_out_hs    = o_output_valid & i_output_ready;

    // State register.
    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a new word arriving on the final handshake keeps us in EMIT.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (w_in_hs) w_state_next = EMIT;
            EMIT: if (w_out_hs && w_last && !w_in_hs) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Outputs are forced to zero outside EMIT so idle/reset values are clean.
    always_comb begin
        o_output_valid = 1'b0;
        o_output_index = '0;
        o_output_last  = 1'b0;
        o_output_empty = 1'b0;
        o_input_ready  = 1'b1;
        if (r_state == EMIT) begin
            o_output_valid = 1'b1;
            o_output_index = w_emit_index;
            o_output_last  = w_last;
            o_output_empty = w_zero;
            o_input_ready  = i_output_ready & w_last;
        end
    end

    // Residual: load on input handshake, otherwise drop the emitted bit.
    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            r_residual <= '0;
        end else if (w_in_hs) begin
            r_residual <= i_input_word;
        end else if (w_out_hs) begin
            r_residual <= w_remaining;
        end
    end

endmodule

// File: tb/tb_set_bit_index_iterator.sv
// Directed bench: LSB-first and MSB-first instances share the same stimulus.
module tb_set_bit_index_iterator;

    logic       clk;
    logic       clear;
    logic [7:0] in_word;
    logic       in_valid;
    logic       out_ready;

    logic       l_in_ready, l_last, l_empty, l_valid;
    logic [3:0] l_index;
    logic       m_in_ready, m_last, m_empty, m_valid;
    logic [3:0] m_index;

    int total = 0;
    int bad   = 0;

    set_bit_index_iterator #(.WORD_WIDTH(8), .SCAN_FROM_MSB(1'b0)) dut_lsb (
        .i_clock        (clk),
        .i_clear        (clear),
        .i_input_word   (in_word),
        .i_input_valid  (in_valid),
        .o_input_ready  (l_in_ready),
        .o_output_index (l_index),
        .o_output_last  (l_last),
        .o_output_empty (l_empty),
        .o_output_valid (l_valid),
        .i_output_ready (out_ready)
    );

    set_bit_index_iterator #(.WORD_WIDTH(8), .SCAN_FROM_MSB(1'b1)) dut_msb (
        .i_clock        (clk),
        .i_clear        (clear),
        .i_input_word   (in_word),
        .i_input_valid  (in_valid),
        .o_input_ready  (m_in_ready),
        .o_output_index (m_index),
        .o_output_last  (m_last),
        .o_output_empty (m_empty),
        .o_output_valid (m_valid),
        .i_output_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        clear = 1'b1; in_valid = 1'b0; in_word = '0; out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        total++; if (l_valid !== 1'b0)  begin bad++; $display("FAIL reset_valid_l got=%b want=0", l_valid); end
        total++; if (l_index !== 4'd0)  begin bad++; $display("FAIL reset_index_l got=%0d want=0", l_index); end
        total++; if (l_last !== 1'b0 || l_empty !== 1'b0) begin bad++; $display("FAIL reset_flags_l got=%b%b want=00", l_last, l_empty); end
        total++; if (l_in_ready !== 1'b1 || m_in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b%b want=11", l_in_ready, m_in_ready); end
        total++; if (m_valid !== 1'b0 || m_index !== 4'd0) begin bad++; $display("FAIL reset_msb got v=%b i=%0d want v=0 i=0", m_valid, m_index); end
    endtask

    task automatic test_basic();
        int exp_l[3];
        int exp_m[3];
        exp_l[0] = 2; exp_l[1] = 5; exp_l[2] = 7;
        exp_m[0] = 7; exp_m[1] = 5; exp_m[2] = 2;
        @(posedge clk); #1;
        in_word = 8'b1010_0100; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++; if (l_valid !== 1'b1 || l_index !== 4'(exp_l[k])) begin bad++; $display("FAIL basic_lsb k=%0d got v=%b i=%0d want v=1 i=%0d", k, l_valid, l_index, exp_l[k]); end
            total++; if (m_valid !== 1'b1 || m_index !== 4'(exp_m[k])) begin bad++; $display("FAIL basic_msb k=%0d got v=%b i=%0d want v=1 i=%0d", k, m_valid, m_index, exp_m[k]); end
            total++; if (l_last !== (k == 2) || m_last !== (k == 2)) begin bad++; $display("FAIL basic_last k=%0d got %b%b want %b", k, l_last, m_last, (k == 2)); end
            total++; if (l_in_ready !== (k == 2) || l_empty !== 1'b0) begin bad++; $display("FAIL basic_in_ready k=%0d got rdy=%b empty=%b want rdy=%b empty=0", k, l_in_ready, l_empty, (k == 2)); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        total++; if (l_valid !== 1'b0 || m_valid !== 1'b0) begin bad++; $display("FAIL basic_idle got %b%b want 00", l_valid, m_valid); end
    endtask

    task automatic test_zero();
        @(posedge clk); #1;
        in_word = 8'h00; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        total++; if (l_valid !== 1'b1 || l_index !== 4'd8 || l_last !== 1'b1 || l_empty !== 1'b1) begin bad++; $display("FAIL zero_lsb got v=%b i=%0d l=%b e=%b want 1 8 1 1", l_valid, l_index, l_last, l_empty); end
        total++; if (m_valid !== 1'b1 || m_index !== 4'd8 || m_last !== 1'b1 || m_empty !== 1'b1) begin bad++; $display("FAIL zero_msb got v=%b i=%0d l=%b e=%b want 1 8 1 1", m_valid, m_index, m_last, m_empty); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (l_valid !== 1'b0 || l_in_ready !== 1'b1 || m_valid !== 1'b0) begin bad++; $display("FAIL zero_idle got v=%b rdy=%b mv=%b want 0 1 0", l_valid, l_in_ready, m_valid); end
    endtask

    task automatic test_backpressure();
        int k = 0;
        int cycles = 0;
        @(posedge clk); #1;
        in_word = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (k < 8 && cycles < 200) begin
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            total++; if (l_valid !== 1'b1 || l_index !== 4'(k)) begin bad++; $display("FAIL bp_lsb k=%0d got v=%b i=%0d want v=1 i=%0d", k, l_valid, l_index, k); end
            total++; if (m_valid !== 1'b1 || m_index !== 4'(7 - k)) begin bad++; $display("FAIL bp_msb k=%0d got v=%b i=%0d want v=1 i=%0d", k, m_valid, m_index, 7 - k); end
            total++; if (l_last !== (k == 7) || m_last !== (k == 7)) begin bad++; $display("FAIL bp_last k=%0d got %b%b want %b", k, l_last, m_last, (k == 7)); end
            if (out_ready) k++;
            cycles++;
            @(posedge clk); #1;
        end
        total++; if (k != 8) begin bad++; $display("FAIL bp_timeout got count=%0d want 8", k); end
        out_ready = 1'b1;
        @(negedge clk);
        total++; if (l_valid !== 1'b0 || m_valid !== 1'b0) begin bad++; $display("FAIL bp_idle got %b%b want 00", l_valid, m_valid); end
    endtask

    task automatic test_back_to_back();
        int exp_l[3];
        int exp_m[3];
        logic exp_last[3];
        exp_l[0] = 0; exp_l[1] = 7; exp_l[2] = 4;
        exp_m[0] = 7; exp_m[1] = 0; exp_m[2] = 4;
        exp_last[0] = 1'b0; exp_last[1] = 1'b1; exp_last[2] = 1'b1;
        @(posedge clk); #1;
        in_word = 8'h81; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_word = 8'h10;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++; if (l_valid !== 1'b1 || l_index !== 4'(exp_l[k]) || l_last !== exp_last[k]) begin bad++; $display("FAIL b2b_lsb k=%0d got v=%b i=%0d l=%b want 1 %0d %b", k, l_valid, l_index, l_last, exp_l[k], exp_last[k]); end
            total++; if (m_valid !== 1'b1 || m_index !== 4'(exp_m[k]) || m_last !== exp_last[k]) begin bad++; $display("FAIL b2b_msb k=%0d got v=%b i=%0d l=%b want 1 %0d %b", k, m_valid, m_index, m_last, exp_m[k], exp_last[k]); end
            total++; if (l_in_ready !== exp_last[k]) begin bad++; $display("FAIL b2b_in_ready k=%0d got %b want %b", k, l_in_ready, exp_last[k]); end
            @(posedge clk); #1;
            if (k == 1) in_valid = 1'b0;
        end
        @(negedge clk);
        total++; if (l_valid !== 1'b0 || m_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle got %b%b want 00", l_valid, m_valid); end
    endtask

    task automatic test_clear();
        @(posedge clk); #1;
        in_word = 8'hF0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        total++; if (l_index !== 4'd4 || m_index !== 4'd7 || l_valid !== 1'b1) begin bad++; $display("FAIL clr_first got l=%0d m=%0d v=%b want 4 7 1", l_index, m_index, l_valid); end
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        total++; if (l_valid !== 1'b0 || l_in_ready !== 1'b1 || l_index !== 4'd0) begin bad++; $display("FAIL clr_state got v=%b rdy=%b i=%0d want 0 1 0", l_valid, l_in_ready, l_index); end
        total++; if (m_valid !== 1'b0 || m_in_ready !== 1'b1) begin bad++; $display("FAIL clr_msb got v=%b rdy=%b want 0 1", m_valid, m_in_ready); end
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            total++; if (l_valid !== 1'b0 || m_valid !== 1'b0) begin bad++; $display("FAIL clr_residual c=%0d got %b%b want 00", c, l_valid, m_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_backpressure();
        test_back_to_back();
        test_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
